rr_grant_ctrl: RTL and testbench

Round-robin arbiter controlling access to one shared resource among N requesters. Each requester holds a request while it needs the resource. The block issues a registered one-hot grant, keeps it until the requester releases, and rotates priority after every grant. It sits in front of shared library datapaths (gate/ALU cells, a bus, a memory port) and also exports the OR-reduction of all requests as a resource-wake signal.

---
 rtl/rr_grant_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rr_grant_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter: registered one-hot grant held until release, one PARK turnaround cycle.
// Optional grant timeout with preempt pulse enabled by defining RR_GRANT_TIMEOUT_EN.
module rr_grant_ctrl #(
   parameter int unsigned N        = 4,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [N-1:0]         i_req,
   output logic [N-1:0]         o_grant,
   output logic [$clog2(N)-1:0] o_grant_id,
   output logic                 o_busy,
   output logic                 o_any_req,
   output logic                 o_preempt
);

   localparam int unsigned IW = $clog2(N);

   if (N < 2 || N > 16) begin : g_bad_n
      $error("rr_grant_ctrl: N must be in 2..16");
   end
   if (MAX_HOLD < 2) begin : g_bad_hold
      $error("rr_grant_ctrl: MAX_HOLD must be at least 2");
   end

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StPark
   } state_e;

   state_e        r_state, w_state_d;
   logic [IW-1:0] r_ptr, w_ptr_d;
   logic [IW-1:0] r_grant_id, w_grant_id_d;
   logic [N-1:0]  r_grant, w_grant_d;
   logic          r_busy, w_busy_d;

   logic          w_found;
   logic [IW-1:0] w_sel;
   logic [IW-1:0] w_idx;
   logic [IW-1:0] w_sel_inc;
   logic          w_release;

`ifdef RR_GRANT_TIMEOUT_EN
   localparam int unsigned HW = $clog2(MAX_HOLD);
   localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);

   logic [HW-1:0] r_hold, w_hold_d;
   logic          r_preempt, w_preempt_d;
`endif

   assign o_any_req = |i_req;

   // First set request bit scanning upward from r_ptr, wrapping mod N.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_idx = IW'((32'(r_ptr) + k) % N);
         if (!w_found && i_req[w_idx]) begin
            w_found = 1'b1;
            w_sel   = w_idx;
         end
      end
   end

   assign w_sel_inc = (w_sel == IW'(N - 1)) ? '0 : w_sel + 1'b1;

   always_comb begin
      w_state_d    = r_state;
      w_ptr_d      = r_ptr;
      w_grant_d    = r_grant;
      w_grant_id_d = r_grant_id;
      w_busy_d     = r_busy;
      w_release    = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
      w_hold_d     = r_hold;
      w_preempt_d  = 1'b0;
`endif
      case (r_state)
         StIdle: begin
            if (w_found) begin
               w_state_d           = StGrant;
               w_grant_d           = '0;
               w_grant_d[w_sel]    = 1'b1;
               w_grant_id_d        = w_sel;
               w_busy_d            = 1'b1;
               w_ptr_d             = w_sel_inc;
`ifdef RR_GRANT_TIMEOUT_EN
               w_hold_d            = '0;
`endif
            end
         end
         StGrant: begin
            if (!i_req[r_grant_id]) begin
               w_release = 1'b1;
            end
`ifdef RR_GRANT_TIMEOUT_EN
            else if (r_hold == HoldLast) begin
               w_release   = 1'b1;
               w_preempt_d = 1'b1;
            end else begin
               w_hold_d = r_hold + 1'b1;
            end
`endif
            if (w_release) begin
               w_state_d    = StPark;
               w_grant_d    = '0;
               w_grant_id_d = '0;
               w_busy_d     = 1'b0;
            end
         end
         StPark: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d    = StIdle;
            w_grant_d    = '0;
            w_grant_id_d = '0;
            w_busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= StIdle;
         r_ptr      <= '0;
         r_grant    <= '0;
         r_grant_id <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_ptr      <= w_ptr_d;
         r_grant    <= w_grant_d;
         r_grant_id <= w_grant_id_d;
         r_busy     <= w_busy_d;
      end
   end

`ifdef RR_GRANT_TIMEOUT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold    <= '0;
         r_preempt <= 1'b0;
      end else begin
         r_hold    <= w_hold_d;
         r_preempt <= w_preempt_d;
      end
   end

   assign o_preempt = r_preempt;
`else
   assign o_preempt = 1'b0;
`endif

   assign o_grant    = r_grant;
   assign o_grant_id = r_grant_id;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: directed vector table, timeout sequence, and randomized run
// checked against a cycle-level reference model (honours RR_GRANT_TIMEOUT_EN).
module tb_rr_grant_ctrl;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] gid;
   logic       busy;
   logic       any_req;
   logic       preempt;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_owner;
   int m_ptr;
   int m_hold;
   bit m_park;
   bit m_pre;

   rr_grant_ctrl #(
      .N        (N),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_req      (req),
      .o_grant    (grant),
      .o_grant_id (gid),
      .o_busy     (busy),
      .o_any_req  (any_req),
      .o_preempt  (preempt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] g;
      logic [1:0] id;
      logic       busy;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                      input logic [1:0] id, input logic b);
      vec_t v;
      v.rst = r; v.req = q; v.g = g; v.id = id; v.busy = b;
      tv.push_back(v);
   endtask

   task automatic drive(input logic r, input logic [3:0] q);
      @(negedge clk);
      rst = r;
      req = q;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                        input logic eb, input logic ep, input logic ea);
      n_checks++;
      if ({grant, gid, busy, preempt, any_req} !== {eg, eid, eb, ep, ea}) begin
         n_fail++;
         $display("FAIL %s: got grant=%b id=%0d busy=%b preempt=%b any_req=%b, want grant=%b id=%0d busy=%b preempt=%b any_req=%b",
                  name, grant, gid, busy, preempt, any_req, eg, eid, eb, ep, ea);
      end
   endtask

   task automatic model_step(input logic r, input logic [3:0] q);
      if (r) begin
         m_owner = -1; m_park = 0; m_ptr = 0; m_hold = 0; m_pre = 0;
      end else if (m_park) begin
         m_park = 0; m_pre = 0;
      end else if (m_owner >= 0) begin
         m_pre = 0;
         if (!q[m_owner]) begin
            m_owner = -1; m_park = 1;
         end
`ifdef RR_GRANT_TIMEOUT_EN
         else if (m_hold >= MAX_HOLD) begin
            m_owner = -1; m_park = 1; m_pre = 1;
         end
`endif
         else begin
            m_hold++;
         end
      end else begin
         m_pre = 0;
         for (int k = 0; k < N; k++) begin
            int w;
            w = (m_ptr + k) % N;
            if (q[w]) begin
               m_owner = w; m_ptr = (w + 1) % N; m_hold = 1;
               break;
            end
         end
      end
   endtask

   initial begin
      logic [3:0] q;
      logic [3:0] eg;
      logic       r;
      rst = 1'b1;
      req = 4'b0000;

      // reset, idle, single request
      add(1, 4'b1111, 4'b0000, 0, 0);
      add(1, 4'b1111, 4'b0000, 0, 0);
      add(0, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b0100, 4'b0100, 2, 1);
      add(0, 4'b0100, 4'b0100, 2, 1);
      add(0, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b0000, 4'b0000, 0, 0);
      // rotation 0,1,2,3 with release-plus-new-request on the same edge
      add(1, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b1111, 4'b0001, 0, 1);
      add(0, 4'b1111, 4'b0001, 0, 1);
      add(0, 4'b1110, 4'b0000, 0, 0);
      add(0, 4'b1110, 4'b0000, 0, 0);
      add(0, 4'b1110, 4'b0010, 1, 1);
      add(0, 4'b1110, 4'b0010, 1, 1);
      add(0, 4'b1100, 4'b0000, 0, 0);
      add(0, 4'b1100, 4'b0000, 0, 0);
      add(0, 4'b1100, 4'b0100, 2, 1);
      add(0, 4'b1100, 4'b0100, 2, 1);
      add(0, 4'b1000, 4'b0000, 0, 0);
      add(0, 4'b1000, 4'b0000, 0, 0);
      add(0, 4'b1000, 4'b1000, 3, 1);
      add(0, 4'b1000, 4'b1000, 3, 1);
      // priority after wrap: 0 beats 3
      add(0, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b1001, 4'b0000, 0, 0);
      add(0, 4'b1001, 4'b0001, 0, 1);
      add(0, 4'b1001, 4'b0001, 0, 1);
      add(0, 4'b1000, 4'b0000, 0, 0);
      add(0, 4'b1000, 4'b0000, 0, 0);
      add(0, 4'b1000, 4'b1000, 3, 1);
      // mid-grant reset
      add(0, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b0010, 4'b0000, 0, 0);
      add(0, 4'b0010, 4'b0010, 1, 1);
      add(1, 4'b0010, 4'b0000, 0, 0);
      add(0, 4'b0110, 4'b0010, 1, 1);
      add(0, 4'b0110, 4'b0010, 1, 1);
      // released requester re-raising in PARK loses to requester 2
      add(0, 4'b0100, 4'b0000, 0, 0);
      add(0, 4'b0110, 4'b0000, 0, 0);
      add(0, 4'b0110, 4'b0100, 2, 1);
      add(0, 4'b0010, 4'b0000, 0, 0);
      add(0, 4'b0010, 4'b0000, 0, 0);
      add(0, 4'b0010, 4'b0010, 1, 1);
      add(1, 4'b0000, 4'b0000, 0, 0);

      foreach (tv[i]) begin
         drive(tv[i].rst, tv[i].req);
         check($sformatf("vec%0d", i), tv[i].g, tv[i].id, tv[i].busy, 1'b0, |tv[i].req);
      end

      // long hold with two requesters
      drive(1, 4'b0011);
      check("to_reset", 4'b0000, 0, 0, 0, 1);
      for (int i = 1; i <= MAX_HOLD; i++) begin
         drive(0, 4'b0011);
         check($sformatf("to_hold%0d", i), 4'b0001, 0, 1, 0, 1);
      end
`ifdef RR_GRANT_TIMEOUT_EN
      drive(0, 4'b0011);
      check("to_preempt", 4'b0000, 0, 0, 1, 1);
      drive(0, 4'b0011);
      check("to_idle", 4'b0000, 0, 0, 0, 1);
      drive(0, 4'b0011);
      check("to_next", 4'b0010, 1, 1, 0, 1);
`else
      for (int i = 0; i < 4; i++) begin
         drive(0, 4'b0011);
         check($sformatf("to_nopre%0d", i), 4'b0001, 0, 1, 0, 1);
      end
`endif

      // randomized traffic against the reference model
      q = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         r = (c == 0) || ($urandom_range(0, 99) == 0);
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 5) == 0) q[b] = ~q[b];
         end
         drive(r, q);
         model_step(r, q);
         eg = 4'b0000;
         if (m_owner >= 0) eg[m_owner] = 1'b1;
         check($sformatf("rand%0d", c), eg, (m_owner >= 0) ? 2'(m_owner) : 2'd0,
               m_owner >= 0, m_pre, |q);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
